// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, op codes,
// interrupt cause codes, mstatus/mie bit positions and WARL masks.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] CSR_MHPMEVENT31   = 12'h33F;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MHPMCOUNTER31 = 12'hB1F;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] CSR_MHPMCOUNTER31H = 12'hB9F;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    typedef enum logic [1:0] {
        CSR_OP_ILL = 2'b00,
        CSR_OP_RW  = 2'b01,
        CSR_OP_RS  = 2'b10,
        CSR_OP_RC  = 2'b11
    } csr_op_e;

    localparam logic [31:0] MCAUSE_M_SW    = 32'h8000_0003;
    localparam logic [31:0] MCAUSE_M_TIMER = 32'h8000_0007;
    localparam logic [31:0] MCAUSE_M_EXT   = 32'h8000_000B;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MSIE     = 3;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;

    localparam logic [1:0]  MSTATUS_MPP_M        = 2'b11;
    localparam logic [31:0] MIE_MASK             = 32'h0000_0888;
    localparam logic [31:0] MTVEC_MASK           = 32'hFFFF_FFFD;
    localparam logic [31:0] MEPC_MASK            = 32'hFFFF_FFFC;
    localparam logic [31:0] MCOUNTEREN_BASE_MASK = 32'h0000_0007;

    function automatic logic [31:0] csr_apply_op(input csr_op_e op, input logic [31:0] old_val,
                                                 input logic [31:0] operand);
        logic [31:0] res;
        res = old_val;
        case (op)
            CSR_OP_RW: res = operand;
            CSR_OP_RS: res = old_val | operand;
            CSR_OP_RC: res = old_val & ~operand;
            default:   res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter built from two CSR-writable 32-bit halves; a write to a
// half wins over that cycle's increment, and a low-half write kills the carry.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        carry;

    always_comb begin
        carry = inc_i && (lo_q == 32'hFFFF_FFFF) && !wr_lo_i;
        lo_d  = wr_lo_i ? wdata_i : lo_q + {31'b0, inc_i};
        hi_d  = wr_hi_i ? wdata_i : hi_q + {31'b0, carry};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign value_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32 core: CSR read/modify/write, trap entry,
// MRET, 64-bit counters and interrupt/trap-target logic. Optional hardware
// performance counters are enabled with the CSR_HPM_EN macro.
module csr_file
    import csr_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          NUM_HPM     = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  csr_valid_i,
    input  logic [2:0]                            funct3_i,
    input  logic [11:0]                           addr_i,
    input  logic [4:0]                            rs1_i,
    input  logic [XLEN-1:0]                       wdata_i,
    output logic [XLEN-1:0]                       rdata_o,
    output logic                                  illegal_o,
    input  logic                                  trap_valid_i,
    input  logic [XLEN-1:0]                       trap_cause_i,
    input  logic [XLEN-1:0]                       trap_pc_i,
    input  logic [XLEN-1:0]                       trap_tval_i,
    input  logic                                  mret_i,
    input  logic                                  instret_i,
    input  logic                                  irq_sw_i,
    input  logic                                  irq_timer_i,
    input  logic                                  irq_ext_i,
    input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event_i,
    output logic                                  irq_take_o,
    output logic [XLEN-1:0]                       irq_cause_o,
    output logic [XLEN-1:0]                       trap_target_o,
    output logic [XLEN-1:0]                       mepc_o
);

    localparam int HPM_W = (NUM_HPM > 0) ? NUM_HPM : 1;

    if (XLEN != 32) begin : g_xlen_check
        $error("csr_file: only XLEN=32 is supported");
    end
    if (NUM_HPM < 0 || NUM_HPM > 29) begin : g_hpm_check
        $error("csr_file: NUM_HPM must be in 0..29");
    end

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mcounteren_q, mcounteren_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] rdata_q, rdata_d;
    logic        illegal_q, illegal_d;

    logic [63:0] mcycle, minstret;
    logic [31:0] mip, pending, old_val, wr_val, hpm_rdata;
    logic        implemented, wr_intent, illegal, csr_we;
    csr_op_e     op;

    // wdata_i already carries the zero-extended zimm, so bit2 needs no decoding
    logic unused_imm_sel;
    assign unused_imm_sel = funct3_i[2];

    assign mip = {20'b0, irq_ext_i, 3'b0, irq_timer_i, 3'b0, irq_sw_i, 3'b0};

    always_comb begin
        old_val     = '0;
        implemented = 1'b1;
        case (addr_i)
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: old_val = '0;
            CSR_MHARTID:    old_val = HART_ID;
            CSR_MSTATUS:    old_val = {19'b0, MSTATUS_MPP_M, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
            CSR_MISA:       old_val = MISA_VALUE;
            CSR_MIE:        old_val = mie_q;
            CSR_MTVEC:      old_val = mtvec_q;
            CSR_MCOUNTEREN: old_val = mcounteren_q;
            CSR_MSCRATCH:   old_val = mscratch_q;
            CSR_MEPC:       old_val = mepc_q;
            CSR_MCAUSE:     old_val = mcause_q;
            CSR_MTVAL:      old_val = mtval_q;
            CSR_MIP:        old_val = mip;
            CSR_MCYCLE:     old_val = mcycle[31:0];
            CSR_MCYCLEH:    old_val = mcycle[63:32];
            CSR_MINSTRET:   old_val = minstret[31:0];
            CSR_MINSTRETH:  old_val = minstret[63:32];
            default: begin
                if (addr_i inside {[CSR_MHPMCOUNTER3:CSR_MHPMCOUNTER31],
                                   [CSR_MHPMCOUNTER3H:CSR_MHPMCOUNTER31H],
                                   [CSR_MHPMEVENT3:CSR_MHPMEVENT31]}) begin
                    old_val = hpm_rdata;
                end else begin
                    implemented = 1'b0;
                end
            end
        endcase
    end

    // misa and read-only counters simply drop writes; only the 11 block rejects them
    assign op        = csr_op_e'(funct3_i[1:0]);
    assign wr_intent = (op == CSR_OP_RW) || (rs1_i != 5'd0);
    assign illegal   = !implemented || (op == CSR_OP_ILL) || (wr_intent && addr_i[11:10] == 2'b11);
    assign csr_we    = csr_valid_i && !illegal && wr_intent && !trap_valid_i;
    assign wr_val    = csr_apply_op(op, old_val, wdata_i);

    csr_counter64 u_mcycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (1'b1),
        .wr_lo_i (csr_we && addr_i == CSR_MCYCLE),
        .wr_hi_i (csr_we && addr_i == CSR_MCYCLEH),
        .wdata_i (wr_val),
        .value_o (mcycle)
    );

    csr_counter64 u_minstret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (instret_i),
        .wr_lo_i (csr_we && addr_i == CSR_MINSTRET),
        .wr_hi_i (csr_we && addr_i == CSR_MINSTRETH),
        .wdata_i (wr_val),
        .value_o (minstret)
    );

`ifdef CSR_HPM_EN
    localparam logic [31:0] MCOUNTEREN_MASK =
        MCOUNTEREN_BASE_MASK | (32'((64'd1 << NUM_HPM) - 64'd1) << 3);
    logic [63:0] hpm_val [HPM_W];

    for (genvar gi = 0; gi < NUM_HPM; gi++) begin : g_hpm
        csr_counter64 u_hpm (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .inc_i   (hpm_event_i[gi]),
            .wr_lo_i (csr_we && addr_i == CSR_MHPMCOUNTER3 + 12'(gi)),
            .wr_hi_i (csr_we && addr_i == CSR_MHPMCOUNTER3H + 12'(gi)),
            .wdata_i (wr_val),
            .value_o (hpm_val[gi])
        );
    end

    always_comb begin
        hpm_rdata = '0;
        for (int k = 0; k < NUM_HPM; k++) begin
            if (addr_i == CSR_MHPMCOUNTER3 + 12'(k))  hpm_rdata = hpm_val[k][31:0];
            if (addr_i == CSR_MHPMCOUNTER3H + 12'(k)) hpm_rdata = hpm_val[k][63:32];
        end
    end
`else
    localparam logic [31:0] MCOUNTEREN_MASK = MCOUNTEREN_BASE_MASK;
    logic unused_hpm;
    assign unused_hpm = ^hpm_event_i;
    assign hpm_rdata  = '0;
`endif

    // Trap entry outranks both the CSR write and MRET; MRET outranks an mstatus write
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mcounteren_d   = mcounteren_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        if (trap_valid_i) begin
            mepc_d         = trap_pc_i & MEPC_MASK;
            mcause_d       = trap_cause_i;
            mtval_d        = trap_tval_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else begin
            if (csr_we) begin
                case (addr_i)
                    CSR_MSTATUS: begin
                        mstatus_mie_d  = wr_val[MSTATUS_MIE];
                        mstatus_mpie_d = wr_val[MSTATUS_MPIE];
                    end
                    CSR_MIE:        mie_d        = wr_val & MIE_MASK;
                    CSR_MTVEC:      mtvec_d      = wr_val & MTVEC_MASK;
                    CSR_MCOUNTEREN: mcounteren_d = wr_val & MCOUNTEREN_MASK;
                    CSR_MSCRATCH:   mscratch_d   = wr_val;
                    CSR_MEPC:       mepc_d       = wr_val & MEPC_MASK;
                    CSR_MCAUSE:     mcause_d     = wr_val;
                    CSR_MTVAL:      mtval_d      = wr_val;
                    default: ;
                endcase
            end
            if (mret_i) begin
                mstatus_mie_d  = mstatus_mpie_q;
                mstatus_mpie_d = 1'b1;
            end
        end
        rdata_d   = csr_valid_i ? (illegal ? 32'd0 : old_val) : rdata_q;
        illegal_d = csr_valid_i && illegal;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET & MTVEC_MASK;
            mcounteren_q   <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            rdata_q        <= '0;
            illegal_q      <= 1'b0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mcounteren_q   <= mcounteren_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            rdata_q        <= rdata_d;
            illegal_q      <= illegal_d;
        end
    end

    assign pending    = mip & mie_q;
    assign irq_take_o = mstatus_mie_q && (pending != 32'd0);

    always_comb begin
        irq_cause_o = '0;
        if (pending[MIE_MEIE])      irq_cause_o = MCAUSE_M_EXT;
        else if (pending[MIE_MSIE]) irq_cause_o = MCAUSE_M_SW;
        else if (pending[MIE_MTIE]) irq_cause_o = MCAUSE_M_TIMER;
    end

    // Vectored mode applies only to interrupts; exceptions always go to the base
    always_comb begin
        trap_target_o = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[0] && trap_cause_i[31]) begin
            trap_target_o = {mtvec_q[31:2], 2'b00} + {25'b0, trap_cause_i[4:0], 2'b00};
        end
    end

    assign rdata_o   = rdata_q;
    assign illegal_o = illegal_q;
    assign mepc_o    = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file: reset, CSR ops and WARL masks,
// traps/MRET, interrupts, 64-bit counters, illegal accesses and HPM addresses.
module tb_csr_file;
    import csr_pkg::*;

    localparam logic [2:0] F_RW  = 3'b001;
    localparam logic [2:0] F_RS  = 3'b010;
    localparam logic [2:0] F_RC  = 3'b011;
    localparam logic [2:0] F_RSI = 3'b110;
    localparam logic [2:0] F_RCI = 3'b111;
`ifdef CSR_HPM_EN
    localparam logic [31:0] EXP_MCOUNTEREN = 32'h0000_007F;
`else
    localparam logic [31:0] EXP_MCOUNTEREN = 32'h0000_0007;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        csr_valid_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [11:0] addr_i = '0;
    logic [4:0]  rs1_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        illegal_o;
    logic        trap_valid_i = 1'b0;
    logic [31:0] trap_cause_i = '0;
    logic [31:0] trap_pc_i = '0;
    logic [31:0] trap_tval_i = '0;
    logic        mret_i = 1'b0;
    logic        instret_i = 1'b0;
    logic        irq_sw_i = 1'b0;
    logic        irq_timer_i = 1'b0;
    logic        irq_ext_i = 1'b0;
    logic [3:0]  hpm_event_i = '0;
    logic        irq_take_o;
    logic [31:0] irq_cause_o;
    logic [31:0] trap_target_o;
    logic [31:0] mepc_o;

    int tests_run = 0;
    int tests_failed = 0;

    csr_file #(
        .XLEN(32), .HART_ID(32'd3), .MISA_VALUE(32'h4000_0100),
        .MTVEC_RESET(32'h0000_0100), .NUM_HPM(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .csr_valid_i(csr_valid_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .rs1_i(rs1_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .illegal_o(illegal_o), .trap_valid_i(trap_valid_i), .trap_cause_i(trap_cause_i),
        .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i), .mret_i(mret_i),
        .instret_i(instret_i), .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i),
        .irq_ext_i(irq_ext_i), .hpm_event_i(hpm_event_i), .irq_take_o(irq_take_o),
        .irq_cause_o(irq_cause_o), .trap_target_o(trap_target_o), .mepc_o(mepc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic csr_op(input logic [2:0] f3, input logic [11:0] addr,
                          input logic [4:0] rs1, input logic [31:0] wd);
        csr_valid_i = 1'b1; funct3_i = f3; addr_i = addr; rs1_i = rs1; wdata_i = wd;
        @(posedge clk_i); #1;
        csr_valid_i = 1'b0;
        $display("[TB] csr f3=%0d addr=%03h rs1=%0d wdata=%08h rdata=%08h illegal=%0b",
                 f3, addr, rs1, wd, rdata_o, illegal_o);
    endtask

    // rs1=0 with non-zero wdata: must read without writing
    task automatic csr_read(input logic [11:0] addr);
        csr_op(F_RS, addr, 5'd0, 32'hFFFF_FFFF);
    endtask

    task automatic test_reset();
        tests_run++; if (rdata_o !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata: got %h want %h", rdata_o, 32'd0); end
        tests_run++; if (illegal_o !== 1'b0) begin tests_failed++; $display("FAIL reset_illegal: got %b want 0", illegal_o); end
        tests_run++; if (mepc_o !== 32'd0) begin tests_failed++; $display("FAIL reset_mepc: got %h want 0", mepc_o); end
        tests_run++; if (irq_take_o !== 1'b0) begin tests_failed++; $display("FAIL reset_irq_take: got %b want 0", irq_take_o); end
        trap_cause_i = 32'h8000_0007; #1;
        tests_run++; if (trap_target_o !== 32'h0000_0100) begin tests_failed++; $display("FAIL reset_trap_target: got %h want %h", trap_target_o, 32'h100); end
        trap_cause_i = 32'd0;
        csr_read(CSR_MSTATUS);
        tests_run++; if (rdata_o !== 32'h0000_1800) begin tests_failed++; $display("FAIL reset_mstatus: got %h want %h", rdata_o, 32'h1800); end
        csr_read(CSR_MTVEC);
        tests_run++; if (rdata_o !== 32'h0000_0100) begin tests_failed++; $display("FAIL reset_mtvec: got %h want %h", rdata_o, 32'h100); end
        csr_read(CSR_MHARTID);
        tests_run++; if (rdata_o !== 32'd3 || illegal_o !== 1'b0) begin tests_failed++; $display("FAIL mhartid: got %h/%b want 3/0", rdata_o, illegal_o); end
        csr_read(CSR_MISA);
        tests_run++; if (rdata_o !== 32'h4000_0100) begin tests_failed++; $display("FAIL misa: got %h want %h", rdata_o, 32'h4000_0100); end
        csr_read(CSR_MSCRATCH);
        tests_run++; if (rdata_o !== 32'd0) begin tests_failed++; $display("FAIL reset_mscratch: got %h want 0", rdata_o); end
        csr_read(CSR_MSCRATCH);
        tests_run++; if (rdata_o !== 32'd0) begin tests_failed++; $display("FAIL rs_x0_nowrite: got %h want 0", rdata_o); end
    endtask

    task automatic test_rw_warl();
        csr_op(F_RW, CSR_MSCRATCH, 5'd1, 32'h0000_00A5);
        tests_run++; if (rdata_o !== 32'd0) begin tests_failed++; $display("FAIL rw_old: got %h want 0", rdata_o); end
        csr_op(F_RC, CSR_MSCRATCH, 5'd1, 32'h0000_0005);
        tests_run++; if (rdata_o !== 32'h0000_00A5) begin tests_failed++; $display("FAIL rc_old: got %h want a5", rdata_o); end
        csr_op(F_RSI, CSR_MSCRATCH, 5'd2, 32'h0000_0002);
        tests_run++; if (rdata_o !== 32'h0000_00A0) begin tests_failed++; $display("FAIL rc_result: got %h want a0", rdata_o); end
        csr_read(CSR_MSCRATCH);
        tests_run++; if (rdata_o !== 32'h0000_00A2) begin tests_failed++; $display("FAIL rsi_result: got %h want a2", rdata_o); end
        csr_op(F_RW, CSR_MEPC, 5'd1, 32'h0000_1003);
        csr_read(CSR_MEPC);
        tests_run++; if (rdata_o !== 32'h0000_1000 || mepc_o !== 32'h0000_1000) begin tests_failed++; $display("FAIL mepc_warl: got %h/%h want 1000", rdata_o, mepc_o); end
        csr_op(F_RW, CSR_MIE, 5'd1, 32'hFFFF_FFFF);
        csr_read(CSR_MIE);
        tests_run++; if (rdata_o !== 32'h0000_0888) begin tests_failed++; $display("FAIL mie_warl: got %h want 888", rdata_o); end
        csr_op(F_RW, CSR_MIE, 5'd1, 32'd0);
        csr_op(F_RW, CSR_MCOUNTEREN, 5'd1, 32'hFFFF_FFFF);
        csr_read(CSR_MCOUNTEREN);
        tests_run++; if (rdata_o !== EXP_MCOUNTEREN) begin tests_failed++; $display("FAIL mcounteren_warl: got %h want %h", rdata_o, EXP_MCOUNTEREN); end
        csr_op(F_RW, CSR_MSTATUS, 5'd1, 32'hFFFF_FFFF);
        csr_read(CSR_MSTATUS);
        tests_run++; if (rdata_o !== 32'h0000_1888) begin tests_failed++; $display("FAIL mstatus_warl: got %h want 1888", rdata_o); end
        csr_op(F_RW, CSR_MSTATUS, 5'd1, 32'd0);
        csr_op(F_RW, CSR_MISA, 5'd1, 32'h1234_5678);
        tests_run++; if (illegal_o !== 1'b0) begin tests_failed++; $display("FAIL misa_write_legal: got %b want 0", illegal_o); end
        csr_read(CSR_MISA);
        tests_run++; if (rdata_o !== 32'h4000_0100) begin tests_failed++; $display("FAIL misa_unchanged: got %h want 40000100", rdata_o); end
    endtask

    task automatic test_trap_target();
        csr_op(F_RW, CSR_MTVEC, 5'd1, 32'h8000_0103);
        csr_read(CSR_MTVEC);
        tests_run++; if (rdata_o !== 32'h8000_0101) begin tests_failed++; $display("FAIL mtvec_warl: got %h want 80000101", rdata_o); end
        trap_cause_i = 32'h0000_0002; #1;
        tests_run++; if (trap_target_o !== 32'h8000_0100) begin tests_failed++; $display("FAIL target_exception: got %h want 80000100", trap_target_o); end
        trap_valid_i = 1'b1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h0000_2000; trap_tval_i = 32'h0000_DEAD; #1;
        tests_run++; if (trap_target_o !== 32'h8000_011C) begin tests_failed++; $display("FAIL target_vectored: got %h want 8000011c", trap_target_o); end
        tick();
        trap_valid_i = 1'b0;
        tests_run++; if (mepc_o !== 32'h0000_2000) begin tests_failed++; $display("FAIL trap_mepc: got %h want 2000", mepc_o); end
        csr_read(CSR_MCAUSE);
        tests_run++; if (rdata_o !== 32'h8000_0007) begin tests_failed++; $display("FAIL trap_mcause: got %h want 80000007", rdata_o); end
        csr_read(CSR_MTVAL);
        tests_run++; if (rdata_o !== 32'h0000_DEAD) begin tests_failed++; $display("FAIL trap_mtval: got %h want dead", rdata_o); end
    endtask

    task automatic test_irq();
        csr_op(F_RW, CSR_MIE, 5'd1, 32'h0000_0880);
        csr_op(F_RSI, CSR_MSTATUS, 5'd8, 32'h0000_0008);
        irq_timer_i = 1'b1; irq_ext_i = 1'b1; #1;
        tests_run++; if (irq_take_o !== 1'b1) begin tests_failed++; $display("FAIL irq_take: got %b want 1", irq_take_o); end
        tests_run++; if (irq_cause_o !== 32'h8000_000B) begin tests_failed++; $display("FAIL irq_cause_ext: got %h want 8000000b", irq_cause_o); end
        csr_read(CSR_MIP);
        tests_run++; if (rdata_o !== 32'h0000_0880) begin tests_failed++; $display("FAIL mip: got %h want 880", rdata_o); end
        trap_valid_i = 1'b1; trap_cause_i = 32'h8000_000B; trap_pc_i = 32'h0000_3000; trap_tval_i = 32'd0;
        tick();
        trap_valid_i = 1'b0;
        tests_run++; if (irq_take_o !== 1'b0) begin tests_failed++; $display("FAIL irq_take_after_trap: got %b want 0", irq_take_o); end
        csr_read(CSR_MSTATUS);
        tests_run++; if (rdata_o !== 32'h0000_1880) begin tests_failed++; $display("FAIL trap_mstatus: got %h want 1880", rdata_o); end
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        csr_read(CSR_MSTATUS);
        tests_run++; if (rdata_o !== 32'h0000_1888) begin tests_failed++; $display("FAIL mret_mstatus: got %h want 1888", rdata_o); end
        csr_op(F_RW, CSR_MIE, 5'd1, 32'h0000_0888);
        irq_ext_i = 1'b0; irq_sw_i = 1'b1; #1;
        tests_run++; if (irq_cause_o !== 32'h8000_0003) begin tests_failed++; $display("FAIL irq_cause_sw: got %h want 80000003", irq_cause_o); end
        irq_sw_i = 1'b0; #1;
        tests_run++; if (irq_cause_o !== 32'h8000_0007) begin tests_failed++; $display("FAIL irq_cause_timer: got %h want 80000007", irq_cause_o); end
        csr_op(F_RCI, CSR_MSTATUS, 5'd8, 32'h0000_0008);
        tests_run++; if (irq_take_o !== 1'b0) begin tests_failed++; $display("FAIL irq_masked: got %b want 0", irq_take_o); end
        irq_timer_i = 1'b0;
    endtask

    task automatic test_counters();
        csr_op(F_RW, CSR_MCYCLEH, 5'd1, 32'd5);
        csr_op(F_RW, CSR_MCYCLE, 5'd1, 32'hFFFF_FFFF);
        tick(); tick();
        csr_read(CSR_MCYCLE);
        tests_run++; if (rdata_o !== 32'd1) begin tests_failed++; $display("FAIL mcycle_wrap: got %h want 1", rdata_o); end
        csr_read(CSR_MCYCLEH);
        tests_run++; if (rdata_o !== 32'd6) begin tests_failed++; $display("FAIL mcycleh_carry: got %h want 6", rdata_o); end
        csr_op(F_RW, CSR_MCYCLE, 5'd1, 32'hFFFF_FFFF);
        csr_op(F_RW, CSR_MCYCLEH, 5'd1, 32'h0000_1234);
        csr_read(CSR_MCYCLEH);
        tests_run++; if (rdata_o !== 32'h0000_1234) begin tests_failed++; $display("FAIL mcycleh_write_wins: got %h want 1234", rdata_o); end
        csr_op(F_RW, CSR_MCYCLE, 5'd1, 32'hFFFF_FFFF);
        csr_op(F_RW, CSR_MCYCLE, 5'd1, 32'h0000_0010);
        csr_read(CSR_MCYCLEH);
        tests_run++; if (rdata_o !== 32'h0000_1234) begin tests_failed++; $display("FAIL carry_suppressed: got %h want 1234", rdata_o); end
        csr_read(CSR_MCYCLE);
        tests_run++; if (rdata_o !== 32'h0000_0011) begin tests_failed++; $display("FAIL mcycle_after_write: got %h want 11", rdata_o); end
        csr_op(F_RW, CSR_MINSTRETH, 5'd1, 32'hFFFF_FFFF);
        csr_op(F_RW, CSR_MINSTRET, 5'd1, 32'hFFFF_FFFE);
        instret_i = 1'b1; tick(); tick(); instret_i = 1'b0;
        csr_read(CSR_MINSTRET);
        tests_run++; if (rdata_o !== 32'd0) begin tests_failed++; $display("FAIL minstret_wrap_lo: got %h want 0", rdata_o); end
        csr_read(CSR_MINSTRETH);
        tests_run++; if (rdata_o !== 32'd0) begin tests_failed++; $display("FAIL minstret_wrap_hi: got %h want 0", rdata_o); end
        for (int i = 0; i < 3; i++) begin
            instret_i = 1'b1; tick(); instret_i = 1'b0; tick();
        end
        csr_read(CSR_MINSTRET);
        tests_run++; if (rdata_o !== 32'd3) begin tests_failed++; $display("FAIL minstret_count: got %h want 3", rdata_o); end
        instret_i = 1'b1;
        csr_op(F_RW, CSR_MINSTRET, 5'd1, 32'h0000_0050);
        instret_i = 1'b0;
        csr_read(CSR_MINSTRET);
        tests_run++; if (rdata_o !== 32'h0000_0050) begin tests_failed++; $display("FAIL minstret_write_wins: got %h want 50", rdata_o); end
    endtask

    task automatic test_illegal();
        csr_read(CSR_MISA);
        tick();
        tests_run++; if (rdata_o !== 32'h4000_0100 || illegal_o !== 1'b0) begin tests_failed++; $display("FAIL rdata_hold: got %h/%b want 40000100/0", rdata_o, illegal_o); end
        csr_op(F_RW, CSR_MVENDORID, 5'd1, 32'd1);
        tests_run++; if (illegal_o !== 1'b1 || rdata_o !== 32'd0) begin tests_failed++; $display("FAIL mvendorid_write: got %b/%h want 1/0", illegal_o, rdata_o); end
        tick();
        tests_run++; if (illegal_o !== 1'b0) begin tests_failed++; $display("FAIL illegal_clears: got %b want 0", illegal_o); end
        csr_read(CSR_MISA);
        csr_read(12'h7C0);
        tests_run++; if (illegal_o !== 1'b1 || rdata_o !== 32'd0) begin tests_failed++; $display("FAIL unimpl_addr: got %b/%h want 1/0", illegal_o, rdata_o); end
        csr_read(CSR_MVENDORID);
        tests_run++; if (illegal_o !== 1'b0) begin tests_failed++; $display("FAIL mvendorid_read: got %b want 0", illegal_o); end
        csr_op(F_RSI, CSR_MHARTID, 5'd1, 32'd1);
        tests_run++; if (illegal_o !== 1'b1) begin tests_failed++; $display("FAIL mhartid_rsi: got %b want 1", illegal_o); end
        csr_op(3'b000, CSR_MSCRATCH, 5'd1, 32'h0000_00FF);
        tests_run++; if (illegal_o !== 1'b1 || rdata_o !== 32'd0) begin tests_failed++; $display("FAIL funct3_000: got %b/%h want 1/0", illegal_o, rdata_o); end
        csr_op(3'b100, CSR_MSCRATCH, 5'd1, 32'h0000_00FF);
        tests_run++; if (illegal_o !== 1'b1) begin tests_failed++; $display("FAIL funct3_100: got %b want 1", illegal_o); end
        csr_read(CSR_MSCRATCH);
        tests_run++; if (rdata_o !== 32'h0000_00A2) begin tests_failed++; $display("FAIL illegal_nowrite: got %h want a2", rdata_o); end
    endtask

    task automatic test_back_to_back();
        trap_valid_i = 1'b1; trap_cause_i = 32'h0000_0002; trap_pc_i = 32'h0000_2000; trap_tval_i = 32'd0;
        csr_op(F_RW, CSR_MEPC, 5'd1, 32'h0000_1000);
        trap_valid_i = 1'b0;
        tests_run++; if (rdata_o !== 32'h0000_3000) begin tests_failed++; $display("FAIL trap_csr_rdata: got %h want 3000", rdata_o); end
        tests_run++; if (mepc_o !== 32'h0000_2000) begin tests_failed++; $display("FAIL trap_beats_write: got %h want 2000", mepc_o); end
        csr_read(CSR_MCAUSE);
        tests_run++; if (rdata_o !== 32'h0000_0002) begin tests_failed++; $display("FAIL trap_csr_mcause: got %h want 2", rdata_o); end
    endtask

    task automatic test_hpm();
`ifdef CSR_HPM_EN
        for (int i = 0; i < 3; i++) begin
            hpm_event_i = 4'b0001; tick(); hpm_event_i = 4'b0000; tick();
        end
        csr_read(CSR_MHPMCOUNTER3);
        tests_run++; if (rdata_o !== 32'd3 || illegal_o !== 1'b0) begin tests_failed++; $display("FAIL hpm3_count: got %h/%b want 3/0", rdata_o, illegal_o); end
        csr_read(CSR_MHPMCOUNTER3H);
        tests_run++; if (rdata_o !== 32'd0) begin tests_failed++; $display("FAIL hpm3h: got %h want 0", rdata_o); end
`else
        csr_op(F_RW, CSR_MHPMCOUNTER3, 5'd1, 32'h0000_0055);
        tests_run++; if (illegal_o !== 1'b0) begin tests_failed++; $display("FAIL hpm_write_legal: got %b want 0", illegal_o); end
        hpm_event_i = 4'b0001; tick(); hpm_event_i = 4'b0000;
        csr_read(CSR_MHPMCOUNTER3);
        tests_run++; if (rdata_o !== 32'd0 || illegal_o !== 1'b0) begin tests_failed++; $display("FAIL hpm_reads_zero: got %h/%b want 0/0", rdata_o, illegal_o); end
`endif
        csr_op(F_RW, CSR_MHPMEVENT3, 5'd1, 32'h0000_0077);
        csr_read(CSR_MHPMEVENT3);
        tests_run++; if (rdata_o !== 32'd0 || illegal_o !== 1'b0) begin tests_failed++; $display("FAIL mhpmevent: got %h/%b want 0/0", rdata_o, illegal_o); end
    endtask

    task automatic test_reset_mid();
        rst_i = 1'b1; instret_i = 1'b1;
        trap_valid_i = 1'b1; trap_cause_i = 32'h0000_0005; trap_pc_i = 32'h0000_4000;
        csr_op(F_RW, CSR_MSCRATCH, 5'd1, 32'h0000_0077);
        rst_i = 1'b0; instret_i = 1'b0; trap_valid_i = 1'b0;
        tests_run++; if (rdata_o !== 32'd0 || illegal_o !== 1'b0) begin tests_failed++; $display("FAIL midreset_rdata: got %h/%b want 0/0", rdata_o, illegal_o); end
        tests_run++; if (mepc_o !== 32'd0) begin tests_failed++; $display("FAIL midreset_mepc: got %h want 0", mepc_o); end
        csr_read(CSR_MSCRATCH);
        tests_run++; if (rdata_o !== 32'd0) begin tests_failed++; $display("FAIL midreset_mscratch: got %h want 0", rdata_o); end
        csr_read(CSR_MTVEC);
        tests_run++; if (rdata_o !== 32'h0000_0100) begin tests_failed++; $display("FAIL midreset_mtvec: got %h want 100", rdata_o); end
        csr_read(CSR_MINSTRET);
        tests_run++; if (rdata_o !== 32'd0) begin tests_failed++; $display("FAIL midreset_minstret: got %h want 0", rdata_o); end
        csr_read(CSR_MCYCLEH);
        tests_run++; if (rdata_o !== 32'd0) begin tests_failed++; $display("FAIL midreset_mcycleh: got %h want 0", rdata_o); end
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        test_reset();
        test_rw_warl();
        test_trap_target();
        test_irq();
        test_counters();
        test_illegal();
        test_back_to_back();
        test_hpm();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
